// File: rtl/sram_pkg.sv
// Shared types and sizing for the cache-to-SRAM responder.
//   sram_state_t : controller FSM states
//   SRAM_ADDR_W  : halfword address width of the off-chip SRAM
//   SRAM_DATA_W  : SRAM data bus width
//   HW_PER_WORD  : halfword beats per 32-bit write
//   HW_PER_BLOCK : halfword beats per 64-bit block read
package sram_pkg;

  localparam int unsigned SRAM_ADDR_W  = 18;
  localparam int unsigned SRAM_DATA_W  = 16;
  localparam int unsigned HW_PER_WORD  = 2;
  localparam int unsigned HW_PER_BLOCK = 4;

  typedef enum logic [1:0] {
    StIdle,
    StRead,
    StWrite,
    StDone
  } sram_state_t;

endpackage

// File: rtl/sram_ctrl.sv
// Responder for the cache request channel. Serialises single-word writes and
// two-word block reads into 16-bit accesses on an asynchronous SRAM.
// Ports:
//   clk, rst                : clock, synchronous active-high reset
//   MEM_R_EN, MEM_W_EN      : level requests, held until ready
//   address, write_data     : word address ([16:0] used) and write word
//   read_data               : returned block, {even word, odd word}
//   ready                   : low while a request is pending or in flight
//   SRAM_DQ                 : bidirectional SRAM data bus
//   SRAM_ADDR               : SRAM halfword address
//   SRAM_*_N                : active-low SRAM strobes
module sram_ctrl
  import sram_pkg::*;
#(
  parameter int unsigned WAIT_CYCLES = 1
) (
  input  logic                   clk,
  input  logic                   rst,
  input  logic                   MEM_R_EN,
  input  logic                   MEM_W_EN,
  input  logic [31:0]            address,
  input  logic [31:0]            write_data,
  output logic [63:0]            read_data,
  output logic                   ready,
  inout  wire  [SRAM_DATA_W-1:0] SRAM_DQ,
  output logic [SRAM_ADDR_W-1:0] SRAM_ADDR,
  output logic                   SRAM_WE_N,
  output logic                   SRAM_OE_N,
  output logic                   SRAM_CE_N,
  output logic                   SRAM_UB_N,
  output logic                   SRAM_LB_N
);

  localparam int unsigned WaitW = $clog2(WAIT_CYCLES + 1);
  // Read beats last WAIT_CYCLES cycles; write beats add one recovery cycle.
  localparam logic [WaitW-1:0] RdLast = WaitW'(WAIT_CYCLES - 1);
  localparam logic [WaitW-1:0] WrLast = WaitW'(WAIT_CYCLES);
  localparam logic [1:0] RdLastBeat = 2'(HW_PER_BLOCK - 1);
  localparam logic       WrLastBeat = 1'(HW_PER_WORD - 1);

  sram_state_t      state_q;
  logic [1:0]       beat_q;
  logic [WaitW-1:0] wait_q;
  logic [16:0]      addr_q;
  logic [31:0]      wdata_q;
  logic [63:0]      read_data_q;
  logic [15:0]      wr_hw;

  logic unused_addr;
  assign unused_addr = ^address[31:17];

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q     <= StIdle;
      beat_q      <= '0;
      wait_q      <= '0;
      addr_q      <= '0;
      wdata_q     <= '0;
      read_data_q <= '0;
    end else begin
      unique case (state_q)
        StIdle: begin
          beat_q <= '0;
          wait_q <= '0;
          // Write wins when both enables are high.
          if (MEM_W_EN) begin
            addr_q  <= address[16:0];
            wdata_q <= write_data;
            state_q <= StWrite;
          end else if (MEM_R_EN) begin
            addr_q  <= {address[16:1], 1'b0};
            state_q <= StRead;
          end
        end
        StRead: begin
          if (wait_q == RdLast) begin
            wait_q <= '0;
            beat_q <= beat_q + 2'd1;
            unique case (beat_q)
              2'd0: read_data_q[47:32] <= SRAM_DQ;
              2'd1: read_data_q[63:48] <= SRAM_DQ;
              2'd2: read_data_q[15:0]  <= SRAM_DQ;
              2'd3: read_data_q[31:16] <= SRAM_DQ;
              default: ;
            endcase
            if (beat_q == RdLastBeat) state_q <= StDone;
          end else begin
            wait_q <= wait_q + 1'b1;
          end
        end
        StWrite: begin
          if (wait_q == WrLast) begin
            wait_q <= '0;
            beat_q <= beat_q + 2'd1;
            if (beat_q[0] == WrLastBeat) state_q <= StDone;
          end else begin
            wait_q <= wait_q + 1'b1;
          end
        end
        StDone: begin
          beat_q  <= '0;
          state_q <= StIdle;
        end
        default: state_q <= StIdle;
      endcase
    end
  end

  // SRAM strobes decode from registered state only.
  always_comb begin
    SRAM_ADDR = '0;
    SRAM_WE_N = 1'b1;
    SRAM_OE_N = 1'b1;
    unique case (state_q)
      StRead: begin
        SRAM_ADDR = {addr_q, 1'b0} + {16'b0, beat_q};
        SRAM_OE_N = 1'b0;
      end
      StWrite: begin
        SRAM_ADDR = {addr_q, 1'b0} + {17'b0, beat_q[0]};
        // Final cycle of each beat keeps address/data with WE_N high.
        SRAM_WE_N = (wait_q == WrLast);
      end
      default: ;
    endcase
  end

  assign wr_hw   = beat_q[0] ? wdata_q[31:16] : wdata_q[15:0];
  assign SRAM_DQ = (state_q == StWrite) ? wr_hw : 16'hzzzz;

  assign ready = (state_q == StDone) ||
                 ((state_q == StIdle) && !MEM_R_EN && !MEM_W_EN);

  assign read_data = read_data_q;
  assign SRAM_CE_N = 1'b0;
  assign SRAM_UB_N = 1'b0;
  assign SRAM_LB_N = 1'b0;

endmodule

// File: tb/tb_sram_ctrl.sv
// Bench for sram_ctrl: behavioural SRAM models, table-driven transactions
// with a scoreboard queue, and hand-written multi-cycle sequences.
module tb_sram_ctrl;

  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  // DUT with default wait
  logic        mem_r_en = 1'b0, mem_w_en = 1'b0;
  logic [31:0] address = '0, write_data = '0;
  logic [63:0] read_data;
  logic        ready;
  wire  [15:0] dq;
  logic [17:0] sram_addr;
  logic        we_n, oe_n, ce_n, ub_n, lb_n;

  sram_ctrl #(.WAIT_CYCLES(1)) dut (
    .clk(clk), .rst(rst), .MEM_R_EN(mem_r_en), .MEM_W_EN(mem_w_en),
    .address(address), .write_data(write_data), .read_data(read_data), .ready(ready),
    .SRAM_DQ(dq), .SRAM_ADDR(sram_addr), .SRAM_WE_N(we_n), .SRAM_OE_N(oe_n),
    .SRAM_CE_N(ce_n), .SRAM_UB_N(ub_n), .SRAM_LB_N(lb_n)
  );

  // DUT with three-cycle beats
  logic        r3_en = 1'b0;
  logic [31:0] address3 = '0;
  logic [63:0] read_data3;
  logic        ready3;
  wire  [15:0] dq3;
  logic [17:0] sram_addr3;
  logic        we3_n, oe3_n, ce3_n, ub3_n, lb3_n;

  sram_ctrl #(.WAIT_CYCLES(3)) dut3 (
    .clk(clk), .rst(rst), .MEM_R_EN(r3_en), .MEM_W_EN(1'b0),
    .address(address3), .write_data(32'h0), .read_data(read_data3), .ready(ready3),
    .SRAM_DQ(dq3), .SRAM_ADDR(sram_addr3), .SRAM_WE_N(we3_n), .SRAM_OE_N(oe3_n),
    .SRAM_CE_N(ce3_n), .SRAM_UB_N(ub3_n), .SRAM_LB_N(lb3_n)
  );

  // SRAM models: async read, write committed on WE_N rising with the address
  // and data last seen while WE_N was low.
  logic [15:0] mem  [0:(1<<18)-1];
  logic [15:0] mem3 [0:(1<<18)-1];
  logic [17:0] wa_l;
  logic [15:0] wd_l;
  logic        tb_drv_en = 1'b0;
  logic [15:0] tb_drv = '0;

  assign dq  = (!oe_n && we_n) ? mem[sram_addr] : (tb_drv_en ? tb_drv : 16'hzzzz);
  assign dq3 = (!oe3_n && we3_n) ? mem3[sram_addr3] : 16'hzzzz;

  always @(negedge clk) begin
    if (!we_n) begin
      wa_l <= sram_addr;
      wd_l <= dq;
    end
  end
  always @(posedge we_n) mem[wa_l] <= wd_l;

  int n_cmp = 0;
  int n_fail = 0;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h, expected %h", name, act, exp);
    end
  endtask

  typedef struct {
    logic        we;
    logic        re;
    logic        hold;   // keep the enable high until ready, else drop after cycle 0
    logic [31:0] addr;
    logic [31:0] wdata;
    int          lat;
    logic [63:0] rd;
    logic [4:0]  we_hi;  // WE_N level in cycles 0..4
  } vec_t;

  typedef struct {
    string       name;
    int          lat;
    logic [63:0] rd;
    logic [4:0]  we_hi;
  } exp_t;

  exp_t sb[$];

  // Starts at 1 time unit after an edge with the DUT idle; returns 1 time unit
  // after the edge that ends DONE. Inputs are scrambled after cycle 0.
  task automatic run_txn(input vec_t v, output int lat, output logic [63:0] rd,
                         output logic [4:0] we_hi);
    lat = -1;
    rd = '0;
    we_hi = '0;
    mem_w_en = v.we;
    mem_r_en = v.re;
    address = v.addr;
    write_data = v.wdata;
    for (int c = 0; c < 40; c++) begin
      @(negedge clk);
      if (ready) begin
        lat = c;
        rd = read_data;
        break;
      end
      if (c < 5) we_hi[c] = we_n;
      @(posedge clk);
      #1;
      if (c == 0) begin
        address = $urandom;
        write_data = $urandom;
        if (!v.hold) begin
          mem_w_en = 1'b0;
          mem_r_en = 1'b0;
        end
      end
    end
    @(posedge clk);
    #1;
    mem_w_en = 1'b0;
    mem_r_en = 1'b0;
  endtask

  vec_t        vecs[5];
  exp_t        e;
  int          lat, t1, t2, lat3, addr_err;
  logic [63:0] rd, rd1, rd2, rd3;
  logic [4:0]  we_hi;

  initial begin
    vecs[0] = '{we: 0, re: 1, hold: 1, addr: 32'h1, wdata: 32'h0, lat: 5,
                rd: 64'h2222_1111_4444_3333, we_hi: 5'h1F};
    vecs[1] = '{we: 1, re: 0, hold: 0, addr: 32'h5, wdata: 32'hDEADBEEF, lat: 5,
                rd: 64'h2222_1111_4444_3333, we_hi: 5'h15};
    vecs[2] = '{we: 1, re: 1, hold: 1, addr: 32'h2, wdata: 32'h12345678, lat: 5,
                rd: 64'h2222_1111_4444_3333, we_hi: 5'h15};
    vecs[3] = '{we: 0, re: 1, hold: 0, addr: 32'h3, wdata: 32'h0, lat: 5,
                rd: 64'h1234_5678_8888_7777, we_hi: 5'h1F};
    vecs[4] = '{we: 0, re: 1, hold: 1, addr: 32'hFFFE_0005, wdata: 32'h0, lat: 5,
                rd: 64'hAAAA_9999_DEAD_BEEF, we_hi: 5'h1F};

    repeat (2) @(posedge clk);
    #1;
    // Reset values while rst is still asserted.
    check("reset ready", 64'(ready), 64'h1);
    check("reset we_n", 64'(we_n), 64'h1);
    check("reset oe_n", 64'(oe_n), 64'h1);
    check("reset addr", 64'(sram_addr), 64'h0);
    check("reset read_data", read_data, 64'h0);
    rst = 1'b0;

    mem[0] = 16'h1111; mem[1] = 16'h2222; mem[2] = 16'h3333; mem[3] = 16'h4444;
    mem[4] = 16'h5555; mem[5] = 16'h6666; mem[6] = 16'h7777; mem[7] = 16'h8888;
    mem[8] = 16'h9999; mem[9] = 16'hAAAA;
    mem3[18'h3FFFC] = 16'h0C0C; mem3[18'h3FFFD] = 16'h0D0D;
    mem3[18'h3FFFE] = 16'h0E0E; mem3[18'h3FFFF] = 16'h0F0F;
    @(posedge clk);
    #1;

    foreach (vecs[i]) begin
      sb.push_back('{name: $sformatf("vec%0d", i), lat: vecs[i].lat, rd: vecs[i].rd,
                     we_hi: vecs[i].we_hi});
      run_txn(vecs[i], lat, rd, we_hi);
      e = sb.pop_front();
      check({e.name, " latency"}, 64'(lat), 64'(e.lat));
      check({e.name, " read_data"}, rd, e.rd);
      check({e.name, " we_n profile"}, 64'(we_hi), 64'(e.we_hi));
    end
    check("mem[0x0A]", 64'(mem[18'h0A]), 64'hBEEF);
    check("mem[0x0B]", 64'(mem[18'h0B]), 64'hDEAD);
    check("mem[0x04]", 64'(mem[18'h04]), 64'h5678);
    check("mem[0x05]", 64'(mem[18'h05]), 64'h1234);

    // Read held high across two blocks.
    sb.push_back('{name: "b2b first", lat: 5, rd: 64'h2222_1111_4444_3333, we_hi: 5'h1F});
    sb.push_back('{name: "b2b second", lat: 6, rd: 64'h1234_5678_8888_7777, we_hi: 5'h1F});
    t1 = -1;
    t2 = -1;
    rd1 = '0;
    rd2 = '0;
    mem_r_en = 1'b1;
    address = 32'h0;
    for (int c = 0; c < 40; c++) begin
      @(negedge clk);
      if (ready) begin
        if (t1 < 0) begin
          t1 = c;
          rd1 = read_data;
        end else begin
          t2 = c;
          rd2 = read_data;
          break;
        end
      end
      @(posedge clk);
      #1;
      if (c == t1) address = 32'h2;
    end
    @(posedge clk);
    #1;
    mem_r_en = 1'b0;
    e = sb.pop_front();
    check({e.name, " latency"}, 64'(t1), 64'(e.lat));
    check({e.name, " read_data"}, rd1, e.rd);
    e = sb.pop_front();
    check({e.name, " gap"}, 64'(t2 - t1), 64'(e.lat));
    check({e.name, " read_data"}, rd2, e.rd);

    // Reset during write beat 0.
    mem_w_en = 1'b1;
    address = 32'h5;
    write_data = 32'h0BADF00D;
    @(posedge clk);
    #1;
    check("rst-write beat0 we_n", 64'(we_n), 64'h0);
    rst = 1'b1;
    mem_w_en = 1'b0;
    @(posedge clk);
    #1;
    check("rst-write we_n", 64'(we_n), 64'h1);
    check("rst-write addr", 64'(sram_addr), 64'h0);
    check("rst-write ready", 64'(ready), 64'h1);
    check("rst-write read_data", read_data, 64'h0);
    rst = 1'b0;
    tb_drv_en = 1'b1;
    tb_drv = 16'hA5C3;
    #1;
    check("rst-write dq released", 64'(dq), 64'hA5C3);
    tb_drv_en = 1'b0;
    @(posedge clk);
    #1;
    check("rst-write mem[0x0B]", 64'(mem[18'h0B]), 64'hDEAD);

    // WAIT_CYCLES = 3, top block of the address space.
    lat3 = -1;
    rd3 = '0;
    addr_err = 0;
    r3_en = 1'b1;
    address3 = 32'h1FFFF;
    for (int c = 0; c < 40; c++) begin
      @(negedge clk);
      if (ready3) begin
        lat3 = c;
        rd3 = read_data3;
        break;
      end
      if (c >= 1 && c <= 12 && sram_addr3 !== 18'(32'h3FFFC + (c - 1) / 3)) begin
        addr_err++;
      end
      @(posedge clk);
      #1;
      if (c == 0) r3_en = 1'b0;
    end
    check("wait3 latency", 64'(lat3), 64'd13);
    check("wait3 read_data", rd3, 64'h0D0D_0C0C_0F0F_0E0E);
    check("wait3 address beats wrong", 64'(addr_err), 64'd0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end

endmodule

// File: doc/sram_ctrl.md
# sram_ctrl

Responder end of the cache-to-SRAM request channel in the MEM stage. Accepts single-word writes and block reads from the 2-way cache. Serialises each one into 16-bit accesses on the off-chip asynchronous SRAM. Holds `ready` low until the access completes, then returns a full 64-bit block (two 32-bit words) for reads.

## Interface
- `WAIT_CYCLES`, default 1: cycles each SRAM halfword beat is held (≥1).
- `clk`  in  1: system clock.
- `rst`  in  1: reset. Synchronous, active-high.
- `MEM_R_EN`  in  1: block read request. Level, held until `ready`.
- `MEM_W_EN`  in  1: word write request. Level, held until `ready`.
- `address`  in  32: word address (byte address −1024, >>2). Only `[16:0]` used.
- `write_data`  in  32: write word.
- `read_data`  out  64: `[63:32]` = even word of the block, `[31:0]` = odd word.
- `ready`  out  1: 0 while a request is pending or in progress; 1 otherwise.
- `SRAM_DQ`  inout  16: SRAM data bus.
- `SRAM_ADDR`  out  18: halfword address.
- `SRAM_WE_N`, `SRAM_OE_N`, `SRAM_CE_N`, `SRAM_UB_N`, `SRAM_LB_N`  out  1 each: active-low SRAM controls.

## Operation
- FSM states: IDLE, READ, WRITE, DONE.
- **IDLE**
  - Write has priority when `MEM_W_EN` and `MEM_R_EN` are both high; the read is ignored.
  - `MEM_W_EN`: latch word address `wa = address[16:0]` and `write_data`; go to WRITE.
  - `MEM_R_EN` alone: latch block base `ba = {address[16:1],1'b0}`; go to READ.
- **READ**: 4 beats, k = 0..3.
  - `SRAM_ADDR = {ba,1'b0} + k`, `OE_N = 0`, `WE_N = 1`, DQ released.
  - Sample DQ at the clock edge ending the beat's last cycle.
  - Beat 0 → `read_data[47:32]`, beat 1 → `[63:48]`, beat 2 → `[15:0]`, beat 3 → `[31:16]`.
  - After beat 3, go to DONE.
- **WRITE**: 2 beats, k = 0..1. Each beat is WAIT_CYCLES+1 cycles.
  - `SRAM_ADDR = {wa,1'b0} + k`; DQ driven with `write_data[15:0]` for k=0, `[31:16]` for k=1.
  - `WE_N = 0` for the first WAIT_CYCLES cycles; `WE_N = 1` in the final cycle, with address and data held (recovery).
  - After beat 1, go to DONE.
- **DONE**: `ready = 1` for exactly one cycle, then IDLE.
- `ready` is combinational from state and inputs:
  - 1 in DONE.
  - 1 in IDLE when neither enable is high.
  - 0 otherwise.
- `CE_N`, `UB_N`, `LB_N` are tied 0.
- In IDLE and DONE: `WE_N = OE_N = 1`, `SRAM_ADDR = 0`, DQ high-Z.
- DQ is driven only in WRITE.
- `read_data` holds its value until the next read's beat 0 overwrites it. Writes never modify it.
- Latched address and data are immune to input changes mid-access.
- A request dropped mid-access does not abort it; the access completes and `ready` still pulses.
- A request still high after DONE is a new request: IDLE accepts it with `ready = 0` that cycle.
- `address[31:17]` is ignored. The halfword address wraps modulo 2^18.

## Timing
- Count cycle 0 as the IDLE cycle in which the request is sampled.
- Read: `ready = 1` in cycle 1+4·WAIT_CYCLES (5 at default); `read_data` is valid in that cycle.
- Write: `ready = 1` in cycle 1+2·(WAIT_CYCLES+1) (5 at default).
- Back-to-back requests: 1 IDLE cycle between DONE and the next access.
- Reset:
  - State → IDLE; beat and wait counters → 0; `read_data` → 0.
  - `ready` → 1 if no request is pending.
  - `WE_N = OE_N = 1`, DQ high-Z, `SRAM_ADDR = 0`.
  - Reset mid-write aborts at the next edge with WE_N deasserted; no partial state is retained.
- All SRAM control outputs decode from registered state and counters only; no combinational path from request inputs.

## Structure
- Package `sram_pkg` holds:
  - State enum `sram_state_t`.
  - `SRAM_ADDR_W = 18`, `SRAM_DATA_W = 16`.
  - `HW_PER_WORD = 2`, `HW_PER_BLOCK = 4`.
- No sub-module; keep the block flat. The DQ tri-state is a single continuous assign inside `sram_ctrl`.
- The bench models the SRAM as a 2^18 × 16 behavioural array with asynchronous read and write on WE_N rising.

## Test plan
- Preload halfwords 0x00:0x1111, 0x01:0x2222, 0x02:0x3333, 0x03:0x4444; read `address` = 1 → `ready` low cycles 0–4, high cycle 5, `read_data = 0x2222_1111_4444_3333`.
- Write `address` = 5, data 0xDEADBEEF → halfword 0x0A = 0xBEEF, 0x0B = 0xDEAD; `ready` in cycle 5; WE_N high in cycles 2 and 4.
- Both enables high, `address` = 2, data 0x12345678 → write performed (0x04 = 0x5678), no read beats, `read_data` unchanged.
- Read request held continuously across two blocks (`address` 0 then 2) → two `ready` pulses 6 cycles apart, second `read_data` from halfwords 0x04–0x07.
- Assert `rst` during write beat 0 → next cycle IDLE, WE_N = 1, DQ high-Z, halfword 0x0B untouched.
- `WAIT_CYCLES` = 3, read `address` = 0x1FFFF → `SRAM_ADDR` 0x3FFFC–0x3FFFF, each held 3 cycles, `ready` in cycle 13.
